// File: rtl/fetch_types_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fetch_types_pkg
//  Purpose  : Shared types for the fetch queue / decode boundary. It holds the
//             fetch entry record, the decoded instruction record, the
//             functional-unit enum and the RV32 major opcodes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package fetch_types_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULDIV = 3'd1,
    FU_LOAD   = 3'd2,
    FU_STORE  = 3'd3,
    FU_BRANCH = 3'd4
  } fu_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    fu_type_e    fu_type;
    logic        is_div;
    logic        writes_rd;
    logic        illegal;
  } decoded_instr_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage
`default_nettype wire

// File: rtl/instr_decode_stage_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rv32im_decoder
//  Purpose  : Purely combinational RV32IM decode of one fetch entry.
//  Ports    : entry   in   fetch_entry_t    raw fetched instruction + pc
//             decoded out  decoded_instr_t  fields, immediate, unit, flags
//  Revision : 1.0  initial release
// ============================================================================
module rv32im_decoder
  import fetch_types_pkg::*;
(
  input  fetch_entry_t   entry,
  output decoded_instr_t decoded
);

  logic [31:0] w;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ill;
  logic        wr;
  logic        unused_valid;

  // The entry valid bit is consumed by the pop logic, not by decode.
  assign unused_valid = entry.valid;

  assign w     = entry.instruction;
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'h000};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  always_comb begin
    decoded             = '0;
    decoded.pc          = entry.pc;
    decoded.instruction = w;
    decoded.opcode      = w[6:0];
    decoded.rd          = w[11:7];
    decoded.rs1         = w[19:15];
    decoded.rs2         = w[24:20];
    decoded.funct3      = w[14:12];
    decoded.funct7      = w[31:25];
    decoded.fu_type     = FU_ALU;
    ill                 = 1'b0;
    wr                  = 1'b0;

    case (w[6:0])
      OPC_OP: begin
        wr = 1'b1;
        if (w[31:25] == 7'h01) begin
          decoded.fu_type = FU_MULDIV;
          decoded.is_div  = w[14];
        end else if (!((w[31:25] == 7'h00) ||
                       ((w[31:25] == 7'h20) &&
                        ((w[14:12] == 3'b000) || (w[14:12] == 3'b101))))) begin
          // Only SUB and SRA use the alternate funct7 encoding.
          ill = 1'b1;
        end
      end
      OPC_OPIMM: begin
        wr          = 1'b1;
        decoded.imm = imm_i;
        // Shift-immediates reuse the funct7 slot; everything else is a plain imm.
        if ((w[14:12] == 3'b001) && (w[31:25] != 7'h00)) begin
          ill = 1'b1;
        end
        if ((w[14:12] == 3'b101) && (w[31:25] != 7'h00) && (w[31:25] != 7'h20)) begin
          ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        wr              = 1'b1;
        decoded.imm     = imm_i;
        decoded.fu_type = FU_LOAD;
      end
      OPC_STORE: begin
        decoded.imm     = imm_s;
        decoded.fu_type = FU_STORE;
      end
      OPC_BRANCH: begin
        decoded.imm     = imm_b;
        decoded.fu_type = FU_BRANCH;
      end
      OPC_JAL: begin
        wr              = 1'b1;
        decoded.imm     = imm_j;
        decoded.fu_type = FU_BRANCH;
      end
      OPC_JALR: begin
        wr              = 1'b1;
        decoded.imm     = imm_i;
        decoded.fu_type = FU_BRANCH;
      end
      OPC_LUI, OPC_AUIPC: begin
        wr          = 1'b1;
        decoded.imm = imm_u;
      end
      default: begin
        ill = 1'b1;
      end
    endcase

    // Illegal entries still flow down the pipe but must not touch state.
    if (ill) begin
      decoded.fu_type = FU_ALU;
      decoded.is_div  = 1'b0;
    end
    decoded.illegal   = ill;
    decoded.writes_rd = wr && !ill && (w[11:7] != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : instr_decode_stage
//  Purpose  : Pops up to ISSUE_WIDTH entries per cycle from the instruction
//             queue, decodes them and holds them in an in-order buffer that
//             dispatch drains oldest-first by a per-cycle count.
//  Ports    : clk, rst (async, active-high), flush (async clear), stall_in
//             deq_valid/deq_data in, deq_ready out   - queue dequeue side
//             disp_take in, dec_valid/dec_data out   - dispatch side
//             occupancy, decoded_count out           - status / perf counter
//  Revision : 1.0  initial release
// ============================================================================
module instr_decode_stage
  import fetch_types_pkg::*;
#(
  parameter int ISSUE_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 stall_in,
  input  logic [ISSUE_WIDTH-1:0]               deq_valid,
  input  fetch_entry_t [ISSUE_WIDTH-1:0]       deq_data,
  output logic [ISSUE_WIDTH-1:0]               deq_ready,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     disp_take,
  output logic [ISSUE_WIDTH-1:0]               dec_valid,
  output decoded_instr_t [ISSUE_WIDTH-1:0]     dec_data,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0]     occupancy,
  output logic [31:0]                          decoded_count
);

  localparam int W  = ISSUE_WIDTH;
  localparam int CW = $clog2(ISSUE_WIDTH+1);

  decoded_instr_t [W-1:0] held;
  decoded_instr_t [W-1:0] held_next;
  decoded_instr_t [W-1:0] lane_dec;
  logic [CW-1:0]          occ;
  logic [CW-1:0]          take;
  logic [CW-1:0]          keep;
  logic [CW-1:0]          free;
  logic [CW-1:0]          lead;
  logic [CW-1:0]          n;
  logic                   run;
  logic [31:0]            count_reg;

  for (genvar g = 0; g < W; g++) begin : g_dec
    rv32im_decoder u_dec (
      .entry   (deq_data[g]),
      .decoded (lane_dec[g])
    );
  end

  // Consume / refill arithmetic. Everything fits in CW bits since all
  // quantities are bounded by W.
  always_comb begin
    take = (disp_take < occ) ? disp_take : occ;
    keep = occ - take;
    free = CW'(W) - keep;

    // Leading ones of the usable valid mask; a lane whose entry carries
    // valid=0 is treated as absent so it can never be popped.
    lead = '0;
    run  = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (run && deq_valid[i] && deq_data[i].valid) begin
        lead = lead + CW'(1);
      end else begin
        run = 1'b0;
      end
    end

    if (stall_in || flush || rst) begin
      n = '0;
    end else begin
      n = (free < lead) ? free : lead;
    end
  end

  always_comb begin
    for (int i = 0; i < W; i++) begin
      deq_ready[i] = (i < int'(n));
      dec_valid[i] = (i < int'(occ));
    end
  end

  // Survivors shift down by take; freshly decoded lanes pack in behind them.
  always_comb begin
    for (int j = 0; j < W; j++) begin
      held_next[j] = '0;
      if (j < int'(keep)) begin
        held_next[j] = held[j + int'(take)];
      end else if (j < int'(keep) + int'(n)) begin
        held_next[j] = lane_dec[j - int'(keep)];
      end
    end
  end

  // Flush shares the asynchronous clear so the outputs drop in the same cycle.
  always_ff @(posedge clk or posedge rst or posedge flush) begin
    if (rst || flush) begin
      held      <= '0;
      occ       <= '0;
      count_reg <= '0;
    end else begin
      held      <= held_next;
      occ       <= keep + n;
      count_reg <= count_reg + 32'(n);
    end
  end

  assign dec_data      = held;
  assign occupancy     = occ;
  assign decoded_count = count_reg;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_instr_decode_stage
//  Purpose  : Self-checking bench. The bench plays the instruction queue
//             (fq) and keeps the expected decode buffer as a queue (mq).
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_decode_stage;
  import fetch_types_pkg::*;

  localparam int W  = 3;
  localparam int CW = $clog2(W+1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic                   stall_in = 1'b0;
  logic [W-1:0]           deq_valid = '0;
  fetch_entry_t [W-1:0]   deq_data = '0;
  logic [W-1:0]           deq_ready;
  logic [CW-1:0]          disp_take = '0;
  logic [W-1:0]           dec_valid;
  decoded_instr_t [W-1:0] dec_data;
  logic [CW-1:0]          occupancy;
  logic [31:0]            decoded_count;

  int checks = 0;
  int errors = 0;

  fetch_entry_t   fq[$];
  decoded_instr_t mq[$];
  logic [31:0]    exp_count = 0;
  logic [31:0]    next_pc = 32'h0000_1000;

  instr_decode_stage #(.ISSUE_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .stall_in      (stall_in),
    .deq_valid     (deq_valid),
    .deq_data      (deq_data),
    .deq_ready     (deq_ready),
    .disp_take     (disp_take),
    .dec_valid     (dec_valid),
    .dec_data      (dec_data),
    .occupancy     (occupancy),
    .decoded_count (decoded_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode written straight from the ISA field definitions.
  function automatic decoded_instr_t ref_decode(input fetch_entry_t e);
    decoded_instr_t d;
    logic [31:0] w;
    int s;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit wr;
    w = e.instruction;
    s = $signed(w);
    op = w[6:0]; f7 = w[31:25]; f3 = w[14:12];
    d = '0;
    d.pc = e.pc; d.instruction = w; d.opcode = op; d.rd = w[11:7];
    d.rs1 = w[19:15]; d.rs2 = w[24:20]; d.funct3 = f3; d.funct7 = f7;
    d.fu_type = FU_ALU;
    wr = 1;
    if (op == OPC_OP) begin
      if (f7 == 7'h01) begin d.fu_type = FU_MULDIV; d.is_div = (f3 >= 3'd4); end
      else if (f7 == 7'h00) d.illegal = 0;
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.illegal = 0;
      else d.illegal = 1;
    end else if (op == OPC_OPIMM) begin
      d.imm = 32'(s >>> 20);
      if (f3 == 3'd1 && f7 != 7'h00) d.illegal = 1;
      if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) d.illegal = 1;
    end else if (op == OPC_LOAD) begin
      d.imm = 32'(s >>> 20); d.fu_type = FU_LOAD;
    end else if (op == OPC_STORE) begin
      d.imm = 32'((s >>> 25) * 32) + 32'(w[11:7]); d.fu_type = FU_STORE; wr = 0;
    end else if (op == OPC_BRANCH) begin
      d.imm = 32'((s >>> 31) * 4096) + 32'(w[7]) * 2048 + 32'(w[30:25]) * 32 + 32'(w[11:8]) * 2;
      d.fu_type = FU_BRANCH; wr = 0;
    end else if (op == OPC_JAL) begin
      d.imm = 32'((s >>> 31) * 1048576) + 32'(w[19:12]) * 4096 + 32'(w[20]) * 2048 + 32'(w[30:21]) * 2;
      d.fu_type = FU_BRANCH;
    end else if (op == OPC_JALR) begin
      d.imm = 32'(s >>> 20); d.fu_type = FU_BRANCH;
    end else if (op == OPC_LUI || op == OPC_AUIPC) begin
      d.imm = w & 32'hFFFF_F000;
    end else begin
      d.illegal = 1;
    end
    if (d.illegal) begin d.fu_type = FU_ALU; d.is_div = 0; end
    d.writes_rd = wr && !d.illegal && (w[11:7] != 0);
    return d;
  endfunction

  task automatic push_instr(input logic [31:0] instr);
    fetch_entry_t e;
    e.valid = 1'b1; e.pc = next_pc; e.instruction = instr;
    next_pc += 4;
    fq.push_back(e);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [10];
    logic [6:0] f7s  [4];
    logic [31:0] w;
    opcs = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
             OPC_JALR, OPC_LUI, OPC_AUIPC, 7'h7F};
    f7s  = '{7'h00, 7'h01, 7'h20, 7'h5A};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 9)];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic check_outputs(input string where);
    logic [W-1:0] ev;
    for (int i = 0; i < W; i++) ev[i] = (i < mq.size());
    chk({where, ".occupancy"}, 160'(occupancy), 160'(mq.size()));
    chk({where, ".dec_valid"}, 160'(dec_valid), 160'(ev));
    chk({where, ".count"}, 160'(decoded_count), 160'(exp_count));
    for (int i = 0; i < W; i++)
      if (i < mq.size()) chk($sformatf("%s.lane%0d", where, i), 160'(dec_data[i]), 160'(mq[i]));
  endtask

  // One clock: drive at negedge, check the pop mask, clock, check the buffer.
  task automatic step(input logic [W-1:0] v, input int dt, input bit st);
    int take, keep, free, lead, n;
    logic [W-1:0] er;
    @(negedge clk);
    while (fq.size() < W) push_instr(rand_instr());
    for (int i = 0; i < W; i++) deq_data[i] = fq[i];
    deq_valid = v; disp_take = CW'(dt); stall_in = st;
    #1;
    take = (dt < mq.size()) ? dt : mq.size();
    keep = mq.size() - take;
    free = W - keep;
    lead = 0;
    while (lead < W && v[lead]) lead++;
    n = st ? 0 : ((free < lead) ? free : lead);
    for (int i = 0; i < W; i++) er[i] = (i < n);
    chk("deq_ready", 160'(deq_ready), 160'(er));
    @(posedge clk);
    repeat (take) void'(mq.pop_front());
    repeat (n) mq.push_back(ref_decode(fq.pop_front()));
    exp_count += 32'(n);
    #1;
    check_outputs("step");
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1; deq_valid = '1; stall_in = 1'b0; disp_take = '0;
    #1;
    chk("flush.dec_valid", 160'(dec_valid), 160'(0));
    chk("flush.deq_ready", 160'(deq_ready), 160'(0));
    chk("flush.occupancy", 160'(occupancy), 160'(0));
    chk("flush.count", 160'(decoded_count), 160'(0));
    @(posedge clk);
    #1;
    chk("flush.hold", 160'(dec_valid), 160'(0));
    @(negedge clk);
    flush = 1'b0; deq_valid = '0;
    mq.delete(); fq.delete(); exp_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_a, pc_b, pc_ill;

    // Reset state
    deq_valid = '1;
    #12;
    chk("rst.deq_ready", 160'(deq_ready), 160'(0));
    chk("rst.dec_valid", 160'(dec_valid), 160'(0));
    chk("rst.occupancy", 160'(occupancy), 160'(0));
    chk("rst.count", 160'(decoded_count), 160'(0));
    chk("rst.dec_data", 160'(dec_data), 160'(0));
    @(negedge clk);
    deq_valid = '0; rst = 1'b0;

    // Three addi's popped in one go, then the full buffer refuses more.
    push_instr(32'h00100093); push_instr(32'h00200113); push_instr(32'h00300193);
    step(3'b111, 0, 0);
    chk("addi.occ", 160'(occupancy), 160'(3));
    chk("addi.rd", 160'(dec_data[0].rd), 160'(1));
    chk("addi.rs1", 160'(dec_data[0].rs1), 160'(0));
    chk("addi.imm", 160'(dec_data[0].imm), 160'(1));
    chk("addi.fu", 160'(dec_data[0].fu_type), 160'(FU_ALU));
    chk("addi.wr", 160'(dec_data[0].writes_rd), 160'(1));
    step(3'b111, 0, 0);
    chk("full.deq_ready", 160'(deq_ready), 160'(0));

    // MUL / DIV / store, then a load.
    fq.delete();
    push_instr(32'h022081B3); push_instr(32'h02114333); push_instr(32'h00102223);
    step(3'b111, 3, 0);
    chk("mul.fu", 160'(dec_data[0].fu_type), 160'(FU_MULDIV));
    chk("mul.is_div", 160'(dec_data[0].is_div), 160'(0));
    chk("mul.regs", 160'({dec_data[0].rd, dec_data[0].rs1, dec_data[0].rs2}), 160'({5'd3, 5'd1, 5'd2}));
    chk("div.fu", 160'(dec_data[1].fu_type), 160'(FU_MULDIV));
    chk("div.is_div", 160'(dec_data[1].is_div), 160'(1));
    chk("div.rd", 160'(dec_data[1].rd), 160'(6));
    chk("sw.fu", 160'(dec_data[2].fu_type), 160'(FU_STORE));
    chk("sw.rs2", 160'(dec_data[2].rs2), 160'(1));
    chk("sw.imm", 160'(dec_data[2].imm), 160'(4));
    chk("sw.wr", 160'(dec_data[2].writes_rd), 160'(0));
    fq.delete();
    push_instr(32'h00C02483);
    step(3'b111, 3, 0);
    chk("lw.fu", 160'(dec_data[0].fu_type), 160'(FU_LOAD));
    chk("lw.rd", 160'(dec_data[0].rd), 160'(9));
    chk("lw.imm", 160'(dec_data[0].imm), 160'(12));

    // Partial dispatch: one leaves, one enters at the tail.
    pc_a = mq[1].pc; pc_b = mq[2].pc;
    step(3'b111, 1, 0);
    chk("partial.pc0", 160'(dec_data[0].pc), 160'(pc_a));
    chk("partial.pc1", 160'(dec_data[1].pc), 160'(pc_b));

    // Stall blocks pops; release resumes them.
    step(3'b000, 3, 0);
    step(3'b011, 0, 1);
    chk("stall.deq_ready", 160'(deq_ready), 160'(0));
    step(3'b011, 0, 0);
    chk("unstall.occ", 160'(occupancy), 160'(2));

    // Flush with two held entries and the queue offering more.
    do_flush();
    push_instr(32'hFFFFFFFF);
    pc_ill = fq[0].pc;
    step(3'b001, 0, 0);
    chk("postflush.dec_valid", 160'(dec_valid), 160'(3'b001));
    chk("ill.pc", 160'(dec_data[0].pc), 160'(pc_ill));
    chk("ill.illegal", 160'(dec_data[0].illegal), 160'(1));
    chk("ill.wr", 160'(dec_data[0].writes_rd), 160'(0));

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_flush();
      step(W'($urandom_range(0, 7)), $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
